// File: rtl/rec_controller_pkg.sv
// Shared types and defaults for the I2S recording controller.
// Holds the FSM state encoding and the default SRAM word-address width.
package rec_ctrl_pkg;

  localparam int ADDR_W_DEF = 20;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RECORD = 2'd1,
    ST_PAUSE  = 2'd2,
    ST_DONE   = 2'd3
  } rec_state_e;

endpackage

// File: rtl/rec_controller_if.sv
// Command, recorder and SRAM-write signals of the recording controller.
// The slave side is the controller; the master side drives commands and observes the SRAM port.
interface rec_controller_if
  import rec_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
);
  logic              i_start;
  logic              i_pause;
  logic              i_stop;
  logic              i_lrc;
  logic [15:0]       i_rec_data;
  logic              o_rec_start;
  logic [ADDR_W-1:0] o_sram_addr;
  logic [15:0]       o_sram_wdata;
  logic              o_sram_we_n;
  logic [ADDR_W:0]   o_rec_len;
  logic [1:0]        o_state;
  logic              o_full;

  modport slave (
    input  i_start, i_pause, i_stop, i_lrc, i_rec_data,
    output o_rec_start, o_sram_addr, o_sram_wdata, o_sram_we_n, o_rec_len, o_state, o_full
  );

  modport master (
    output i_start, i_pause, i_stop, i_lrc, i_rec_data,
    input  o_rec_start, o_sram_addr, o_sram_wdata, o_sram_we_n, o_rec_len, o_state, o_full
  );
endinterface

// File: rtl/rec_controller_lrc_edge_det.sv
// Rising-edge detector for the I2S left/right clock.
// rise is combinational: high in the cycle lrc is 1 and its one-cycle-old copy is 0.
module lrc_edge_det (
  input  logic i_clk,
  input  logic i_rst,
  input  logic lrc,
  output logic rise
);
  logic lrc_q;
  logic lrc_d;

  always_comb begin
    lrc_d = lrc;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      lrc_q <= 1'b0;
    end else begin
      lrc_q <= lrc_d;
    end
  end

  assign rise = lrc & ~lrc_q;
endmodule

// File: rtl/rec_controller.sv
// Recording controller: writes one I2S sample per lrc rising edge into SRAM, with pause/stop/full handling.
// Write strobe lands one cycle after the sample event; the first event after (re)entering RECORD is skipped.
module rec_controller
  import rec_ctrl_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] MAX_ADDR = {ADDR_W{1'b1}}
) (
  input  logic            i_clk,
  input  logic            i_rst,
  rec_controller_if.slave bus
);
  rec_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic              full_q, full_d;
  logic              skip_q, skip_d;
  logic              we_n_q, we_n_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              rec_start_q, rec_start_d;
  logic              lrc_rise;
  logic              hit_max;

  lrc_edge_det u_lrc_edge_det (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .lrc   (bus.i_lrc),
    .rise  (lrc_rise)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    full_d      = full_q;
    skip_d      = skip_q;
    we_n_d      = 1'b1;
    wdata_d     = wdata_q;
    rec_start_d = 1'b0;
    hit_max     = 1'b0;

    // An issued strobe always retires here, whatever the state has moved to.
    if (!we_n_q) begin
      len_d = len_q + 1'b1;
      if (addr_q == MAX_ADDR) begin
        full_d  = 1'b1;
        hit_max = 1'b1;
      end else begin
        addr_d = addr_q + 1'b1;
      end
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.i_start) begin
          addr_d      = '0;
          len_d       = '0;
          full_d      = 1'b0;
          skip_d      = 1'b1;
          rec_start_d = 1'b1;
          state_d     = ST_RECORD;
        end
      end
      ST_RECORD: begin
        if (bus.i_stop) begin
          state_d = ST_DONE;
        end else if (bus.i_pause) begin
          state_d = ST_PAUSE;
        end else if (lrc_rise) begin
          // The first edge after entry may belong to a half-captured frame.
          if (skip_q) begin
            skip_d = 1'b0;
          end else begin
            we_n_d  = 1'b0;
            wdata_d = bus.i_rec_data;
          end
        end
      end
      ST_PAUSE: begin
        if (bus.i_stop) begin
          state_d = ST_DONE;
        end else if (bus.i_start) begin
          skip_d  = 1'b1;
          state_d = ST_RECORD;
        end
      end
    endcase

    if (hit_max) begin
      state_d = ST_DONE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      full_q      <= 1'b0;
      skip_q      <= 1'b0;
      we_n_q      <= 1'b1;
      wdata_q     <= '0;
      rec_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      full_q      <= full_d;
      skip_q      <= skip_d;
      we_n_q      <= we_n_d;
      wdata_q     <= wdata_d;
      rec_start_q <= rec_start_d;
    end
  end

  assign bus.o_rec_start  = rec_start_q;
  assign bus.o_sram_addr  = addr_q;
  assign bus.o_sram_wdata = wdata_q;
  assign bus.o_sram_we_n  = we_n_q;
  assign bus.o_rec_len    = len_q;
  assign bus.o_state      = state_q;
  assign bus.o_full       = full_q;
endmodule

// File: tb/tb_rec_controller.sv
// Directed bench for rec_controller: default-size instance plus a MAX_ADDR=3 instance sharing stimulus.
module tb_rec_controller;
  import rec_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic        stop = 1'b0;
  logic        lrc = 1'b0;
  logic [15:0] data = 16'h0;

  int checks = 0;
  int errors = 0;
  int starts = 0;

  logic [19:0] wa[$];
  logic [15:0] wd[$];
  logic [3:0]  sa[$];
  logic [15:0] sd[$];

  always #5 clk = ~clk;

  rec_controller_if #(.ADDR_W(20)) bus ();
  rec_controller_if #(.ADDR_W(4))  bus3 ();

  assign bus.i_start     = start;
  assign bus.i_pause     = pause;
  assign bus.i_stop      = stop;
  assign bus.i_lrc       = lrc;
  assign bus.i_rec_data  = data;
  assign bus3.i_start    = start;
  assign bus3.i_pause    = pause;
  assign bus3.i_stop     = stop;
  assign bus3.i_lrc      = lrc;
  assign bus3.i_rec_data = data;

  rec_controller #(.ADDR_W(20)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  rec_controller #(.ADDR_W(4), .MAX_ADDR(4'd3)) dut3 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus3.slave)
  );

  always @(negedge clk) begin
    if (!rst) begin
      if (!bus.o_sram_we_n) begin
        wa.push_back(bus.o_sram_addr);
        wd.push_back(bus.o_sram_wdata);
      end
      if (!bus3.o_sram_we_n) begin
        sa.push_back(bus3.o_sram_addr);
        sd.push_back(bus3.o_sram_wdata);
      end
      if (bus.o_rec_start) starts++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    wa.delete();
    wd.delete();
    sa.delete();
    sd.delete();
    starts = 0;
  endtask

  task automatic lrc_edge(input logic [15:0] d);
    data = d;
    lrc  = 1'b1;
    repeat (3) tick();
    lrc = 1'b0;
    repeat (3) tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_pause();
    pause = 1'b1;
    tick();
    pause = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    lrc = 1'b1;
    tick();
    tick();
    checks++; if (bus.o_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", bus.o_state); end
    checks++; if (bus.o_sram_we_n !== 1'b1) begin errors++; $display("FAIL reset_we_n: got %0b expected 1", bus.o_sram_we_n); end
    checks++; if (bus.o_rec_start !== 1'b0) begin errors++; $display("FAIL reset_rec_start: got %0b expected 0", bus.o_rec_start); end
    checks++; if (bus.o_sram_addr !== 20'h0) begin errors++; $display("FAIL reset_addr: got %0h expected 0", bus.o_sram_addr); end
    checks++; if (bus.o_sram_wdata !== 16'h0) begin errors++; $display("FAIL reset_wdata: got %0h expected 0", bus.o_sram_wdata); end
    checks++; if (bus.o_rec_len !== 21'h0) begin errors++; $display("FAIL reset_len: got %0h expected 0", bus.o_rec_len); end
    checks++; if (bus.o_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %0b expected 0", bus.o_full); end
    lrc = 1'b0;
    do_reset();
  endtask

  task automatic test_basic();
    logic [15:0] exp_d[3];
    exp_d = '{16'h2222, 16'h3333, 16'h4444};
    do_reset();
    pulse_start();
    checks++; if (bus.o_state !== 2'd1) begin errors++; $display("FAIL basic_state_record: got %0d expected 1", bus.o_state); end
    lrc_edge(16'h1111);
    lrc_edge(16'h2222);
    lrc_edge(16'h3333);
    lrc_edge(16'h4444);
    checks++; if (wa.size() !== 3) begin errors++; $display("FAIL basic_write_count: got %0d expected 3", wa.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= wa.size() || wa[i] !== 20'(i) || wd[i] !== exp_d[i]) begin
        errors++;
        $display("FAIL basic_write%0d: got addr %0h data %0h expected addr %0h data %0h",
                 i, (i < wa.size()) ? wa[i] : 20'hxxxxx, (i < wd.size()) ? wd[i] : 16'hxxxx, i, exp_d[i]);
      end
    end
    checks++; if (bus.o_rec_len !== 21'd3) begin errors++; $display("FAIL basic_len: got %0d expected 3", bus.o_rec_len); end
    checks++; if (starts !== 1) begin errors++; $display("FAIL basic_rec_start_count: got %0d expected 1", starts); end
    checks++; if (bus.o_sram_we_n !== 1'b1) begin errors++; $display("FAIL basic_we_n_idle: got %0b expected 1", bus.o_sram_we_n); end
  endtask

  task automatic test_pause_resume();
    logic [15:0] exp_d[4];
    exp_d = '{16'h0A02, 16'h0A03, 16'h0C02, 16'h0C03};
    do_reset();
    pulse_start();
    lrc_edge(16'h0A01);
    lrc_edge(16'h0A02);
    lrc_edge(16'h0A03);
    pulse_pause();
    checks++; if (bus.o_state !== 2'd2) begin errors++; $display("FAIL pause_state: got %0d expected 2", bus.o_state); end
    lrc_edge(16'h0B01);
    lrc_edge(16'h0B02);
    lrc_edge(16'h0B03);
    checks++; if (wa.size() !== 2) begin errors++; $display("FAIL pause_no_writes: got %0d writes expected 2", wa.size()); end
    pulse_start();
    checks++; if (bus.o_state !== 2'd1) begin errors++; $display("FAIL resume_state: got %0d expected 1", bus.o_state); end
    lrc_edge(16'h0C01);
    lrc_edge(16'h0C02);
    lrc_edge(16'h0C03);
    checks++; if (wa.size() !== 4) begin errors++; $display("FAIL resume_write_count: got %0d expected 4", wa.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= wa.size() || wa[i] !== 20'(i) || wd[i] !== exp_d[i]) begin
        errors++;
        $display("FAIL resume_write%0d: got addr %0h data %0h expected addr %0h data %0h",
                 i, (i < wa.size()) ? wa[i] : 20'hxxxxx, (i < wd.size()) ? wd[i] : 16'hxxxx, i, exp_d[i]);
      end
    end
    checks++; if (bus.o_rec_len !== 21'd4) begin errors++; $display("FAIL resume_len: got %0d expected 4", bus.o_rec_len); end
    checks++; if (starts !== 1) begin errors++; $display("FAIL resume_rec_start_count: got %0d expected 1", starts); end
  endtask

  task automatic test_full();
    do_reset();
    pulse_start();
    for (int i = 0; i < 6; i++) lrc_edge(16'hA000 + 16'(i));
    checks++; if (sa.size() !== 4) begin errors++; $display("FAIL full_write_count: got %0d expected 4", sa.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= sa.size() || sa[i] !== 4'(i) || sd[i] !== 16'hA001 + 16'(i)) begin
        errors++;
        $display("FAIL full_write%0d: got addr %0h data %0h expected addr %0h data %0h",
                 i, (i < sa.size()) ? sa[i] : 4'hx, (i < sd.size()) ? sd[i] : 16'hxxxx, i, 16'hA001 + 16'(i));
      end
    end
    checks++; if (bus3.o_full !== 1'b1) begin errors++; $display("FAIL full_flag: got %0b expected 1", bus3.o_full); end
    checks++; if (bus3.o_state !== 2'd3) begin errors++; $display("FAIL full_state: got %0d expected 3", bus3.o_state); end
    checks++; if (bus3.o_rec_len !== 5'd4) begin errors++; $display("FAIL full_len: got %0d expected 4", bus3.o_rec_len); end
    checks++; if (bus3.o_sram_addr !== 4'd3) begin errors++; $display("FAIL full_addr_no_wrap: got %0d expected 3", bus3.o_sram_addr); end
    pulse_start();
    checks++; if (bus3.o_full !== 1'b0) begin errors++; $display("FAIL full_restart_flag: got %0b expected 0", bus3.o_full); end
    checks++; if (bus3.o_sram_addr !== 4'd0) begin errors++; $display("FAIL full_restart_addr: got %0d expected 0", bus3.o_sram_addr); end
    checks++; if (bus3.o_rec_len !== 5'd0) begin errors++; $display("FAIL full_restart_len: got %0d expected 0", bus3.o_rec_len); end
  endtask

  task automatic test_stop_on_edge();
    do_reset();
    pulse_start();
    lrc_edge(16'h1111);
    lrc_edge(16'h2222);
    data = 16'h3333;
    lrc  = 1'b1;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    repeat (2) tick();
    lrc = 1'b0;
    repeat (3) tick();
    checks++; if (wa.size() !== 1) begin errors++; $display("FAIL stop_edge_writes: got %0d expected 1", wa.size()); end
    checks++; if (bus.o_state !== 2'd3) begin errors++; $display("FAIL stop_edge_state: got %0d expected 3", bus.o_state); end
    checks++; if (bus.o_rec_len !== 21'd1) begin errors++; $display("FAIL stop_edge_len: got %0d expected 1", bus.o_rec_len); end
    pulse_start();
    checks++; if (bus.o_sram_addr !== 20'd0) begin errors++; $display("FAIL restart_addr: got %0h expected 0", bus.o_sram_addr); end
    checks++; if (bus.o_rec_len !== 21'd0) begin errors++; $display("FAIL restart_len: got %0d expected 0", bus.o_rec_len); end
    checks++; if (bus.o_full !== 1'b0) begin errors++; $display("FAIL restart_full: got %0b expected 0", bus.o_full); end
    checks++; if (bus.o_state !== 2'd1) begin errors++; $display("FAIL restart_state: got %0d expected 1", bus.o_state); end
  endtask

  task automatic test_reset_midwrite();
    do_reset();
    pulse_start();
    lrc_edge(16'h5555);
    data = 16'h6666;
    lrc  = 1'b1;
    tick();
    checks++; if (bus.o_sram_we_n !== 1'b0) begin errors++; $display("FAIL midwrite_strobe_low: got %0b expected 0", bus.o_sram_we_n); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bus.o_sram_we_n !== 1'b1) begin errors++; $display("FAIL midwrite_we_n: got %0b expected 1", bus.o_sram_we_n); end
    checks++; if (bus.o_state !== 2'd0) begin errors++; $display("FAIL midwrite_state: got %0d expected 0", bus.o_state); end
    checks++; if (bus.o_sram_addr !== 20'd0) begin errors++; $display("FAIL midwrite_addr: got %0h expected 0", bus.o_sram_addr); end
    checks++; if (bus.o_sram_wdata !== 16'h0) begin errors++; $display("FAIL midwrite_wdata: got %0h expected 0", bus.o_sram_wdata); end
    checks++; if (bus.o_rec_len !== 21'd0) begin errors++; $display("FAIL midwrite_len: got %0d expected 0", bus.o_rec_len); end
    checks++; if (bus.o_full !== 1'b0) begin errors++; $display("FAIL midwrite_full: got %0b expected 0", bus.o_full); end
    checks++; if (bus.o_rec_start !== 1'b0) begin errors++; $display("FAIL midwrite_rec_start: got %0b expected 0", bus.o_rec_start); end
    lrc = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_commands();
    do_reset();
    pulse_pause();
    checks++; if (bus.o_state !== 2'd0) begin errors++; $display("FAIL idle_pause_ignored: got %0d expected 0", bus.o_state); end
    pulse_stop();
    checks++; if (bus.o_state !== 2'd0) begin errors++; $display("FAIL idle_stop_ignored: got %0d expected 0", bus.o_state); end
    pulse_start();
    pulse_pause();
    pulse_pause();
    checks++; if (bus.o_state !== 2'd2) begin errors++; $display("FAIL pause_pause_ignored: got %0d expected 2", bus.o_state); end
    pulse_start();
    start = 1'b1;
    pause = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    pause = 1'b0;
    stop  = 1'b0;
    checks++; if (bus.o_state !== 2'd3) begin errors++; $display("FAIL all_cmds_state: got %0d expected 3", bus.o_state); end
    checks++; if (starts !== 1) begin errors++; $display("FAIL cmds_rec_start_count: got %0d expected 1", starts); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pause_resume();
    test_full();
    test_stop_on_edge();
    test_reset_midwrite();
    test_commands();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rec_controller.md
REC_CONTROLLER -- requirements
Module: rec_controller

Interface
REQ-001 Parameter ADDR_W, default 20, SHALL be the SRAM word-address width.
REQ-002 Parameter MAX_ADDR, default 2**ADDR_W-1, SHALL be the last writable word address.
REQ-003 i_clk  input  1  SHALL be the single clock (audio bit clock, same domain as the recorder); one clock only.
REQ-004 i_rst  input  1  SHALL be the reset; reset is synchronous and active-high.
REQ-005 i_start  input  1  SHALL be a one-cycle pulse that starts a new recording, or resumes from PAUSE.
REQ-006 i_pause  input  1  SHALL be a one-cycle pulse that requests pause.
REQ-007 i_stop  input  1  SHALL be a one-cycle pulse that requests stop.
REQ-008 i_lrc  input  1  SHALL be the raw I2S left/right clock.
REQ-009 i_rec_data  input  16  SHALL be the latest sample word from the recorder.
REQ-010 o_rec_start  output  1  SHALL be a one-cycle start pulse to the recorder.
REQ-011 o_sram_addr  output  ADDR_W  SHALL be the SRAM write address.
REQ-012 o_sram_wdata  output  16  SHALL be the SRAM write data.
REQ-013 o_sram_we_n  output  1  SHALL be the active-low SRAM write strobe.
REQ-014 o_rec_len  output  ADDR_W+1  SHALL be the count of samples written in the current recording.
REQ-015 o_state  output  2  SHALL be the encoded FSM state.
REQ-016 o_full  output  1  SHALL be high when MAX_ADDR has been written.

Function
REQ-017 FSM states SHALL be IDLE=0, RECORD=1, PAUSE=2, DONE=3.
REQ-018 Command priority in one cycle SHALL be stop > pause > start.
REQ-019 IDLE or DONE + i_start: clear address, o_rec_len and o_full; pulse o_rec_start in the next cycle; set skip flag; go to RECORD.
REQ-020 RECORD + i_pause -> PAUSE; RECORD + i_stop -> DONE.
REQ-021 PAUSE + i_start -> RECORD without clearing address or length; the skip flag SHALL be set again; o_rec_start SHALL NOT pulse.
REQ-022 PAUSE + i_stop -> DONE; i_pause SHALL be ignored outside RECORD, and i_stop SHALL be ignored in IDLE and DONE.
REQ-023 A sample event SHALL be the rising edge of i_lrc, detected against i_lrc registered one cycle.
REQ-024 In RECORD, the first sample event after entry SHALL only clear the skip flag; each later event SHALL write the sample.
REQ-025 Write cycle: o_sram_we_n SHALL be low for exactly one cycle, one cycle after the event, with o_sram_wdata = i_rec_data sampled at the event and o_sram_addr = current address.
REQ-026 After each write, address and o_rec_len SHALL increment by 1; the address SHALL never wrap.
REQ-027 A write to MAX_ADDR SHALL set o_full and move the FSM to DONE in the same cycle the strobe deasserts.
REQ-028 A pause or stop arriving in the same cycle as a sample event SHALL win, and no write SHALL occur.
REQ-029 An already-issued write strobe SHALL complete even if the state leaves RECORD.
REQ-030 o_sram_we_n SHALL be high in every state except during a write cycle in RECORD.

Reset
REQ-031 While i_rst is high at a clock edge, state SHALL be IDLE, o_sram_we_n=1, o_rec_start=0, o_sram_addr=0, o_sram_wdata=0, o_rec_len=0, o_full=0, the skip flag clear, and registered lrc=0.
REQ-032 Reset SHALL abort any in-flight write, including mid-RECORD, with the strobe high in the following cycle.

Structure
REQ-033 Package rec_ctrl_pkg SHALL hold the state enum and the default ADDR_W constant.
REQ-034 The edge detector SHALL be the sub-module lrc_edge_det (input lrc, output one-cycle rise pulse); all other logic SHALL be in rec_controller.

Verification
REQ-035 Reset, then start; drive 4 lrc rising edges with data 0x1111, 0x2222, 0x3333, 0x4444 -> 3 writes of 0x2222, 0x3333, 0x4444 at addresses 0, 1, 2; o_rec_len=3.
REQ-036 Pause after 2 writes, 3 lrc edges, then start and 3 more edges -> no writes while paused; after resume 2 writes at addresses 2 and 3; o_rec_start pulses exactly once in total.
REQ-037 MAX_ADDR=3, start, 6 edges -> 4 writes at addresses 0-3, o_full=1, state DONE, no write at address 4.
REQ-038 Stop in the same cycle as an lrc rising edge -> no write, state DONE; a following start -> address 0, o_rec_len=0, o_full=0.
REQ-039 Assert i_rst for one cycle while o_sram_we_n is low -> strobe high in the next cycle, all outputs at reset values, state IDLE.
REQ-040 Start, pause and stop all in one cycle from RECORD -> DONE.
